// File: rtl/reg_file.sv
// Two-read/one-write register file with a debug read port and a wrapping write counter; x0 reads as zero.
// Latency: reads are combinational (0 cycles) with no write bypass; writes commit on the rising clk edge.
// Backpressure: none. A write is accepted every cycle that RegWrite is high and WriteReg is non-zero.
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] DbgReg,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] DbgData,
    output logic [15:0]       WriteCount
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [15:0]       wr_cnt;
    logic              wr_en;

    // Writes to x0 are dropped entirely, so they are not counted either.
    assign wr_en = RegWrite && (WriteReg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_cnt <= '0;
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
            wr_cnt         <= wr_cnt + 16'd1;
        end
    end

    // Deliberately no bypass from WriteData: it would close a combinational loop through the ALU.
    assign ReadData1  = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
    assign ReadData2  = (ReadReg2 == '0) ? '0 : regs[ReadReg2];
    assign DbgData    = (DbgReg   == '0) ? '0 : regs[DbgReg];
    assign WriteCount = wr_cnt;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected port values, a negedge monitor pops and compares.
module tb_reg_file;

    localparam int P_RD1 = 0;
    localparam int P_RD2 = 1;
    localparam int P_DBG = 2;
    localparam int P_CNT = 3;

    typedef struct {
        int          tag;
        int          port;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  DbgReg;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] DbgData;
    logic [15:0] WriteCount;

    chk_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          tag      = 0;
    logic [31:0] model [32];

    reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .DbgReg     (DbgReg),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .DbgData    (DbgData),
        .WriteCount (WriteCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown(RegWrite))
                else $error("FAIL regwrite_x: RegWrite=%b while out of reset", RegWrite);
        end
    end

    // Monitor: reads outputs on the falling edge, away from the commit edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            string       nm;
            c = sb_q.pop_front();
            case (c.port)
                P_RD1:   begin act = ReadData1;          nm = "ReadData1";  end
                P_RD2:   begin act = ReadData2;          nm = "ReadData2";  end
                P_DBG:   begin act = DbgData;            nm = "DbgData";    end
                default: begin act = {16'h0, WriteCount}; nm = "WriteCount"; end
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL chk%0d %s: got 0x%08h expected 0x%08h at %0t", c.tag, nm, act, c.exp, $time);
            end
        end
    end

    task automatic expect_val(input int port, input logic [31:0] val);
        chk_t c;
        c.tag  = tag;
        c.port = port;
        c.exp  = val;
        sb_q.push_back(c);
        tag++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] dat);
        RegWrite  = 1'b1;
        WriteReg  = idx;
        WriteData = dat;
        if (idx != 5'd0) model[idx] = dat;
        step();
        RegWrite  = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        int budget;
        model_clear();

        // Reset state, with a write attempted while reset is held.
        rst_n = 1'b0; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hAAAA5555;
        ReadReg1 = 5'd3; ReadReg2 = 5'd0; DbgReg = 5'd3;
        expect_val(P_RD1, 32'h0); expect_val(P_DBG, 32'h0); expect_val(P_CNT, 32'h0);
        step();
        rst_n = 1'b1; RegWrite = 1'b0;
        expect_val(P_RD1, 32'h0); expect_val(P_CNT, 32'h0);
        step();

        // Write 0xDEADBEEF to x5: old value before the edge, new value after.
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
        ReadReg1 = 5'd5; ReadReg2 = 5'd5;
        expect_val(P_RD1, 32'h0); expect_val(P_CNT, 32'h0);
        step();
        RegWrite = 1'b0;
        model[5] = 32'hDEADBEEF;
        expect_val(P_RD1, 32'hDEADBEEF); expect_val(P_RD2, 32'hDEADBEEF); expect_val(P_CNT, 32'd1);
        step();

        // Write to x0 is discarded and uncounted.
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; ReadReg1 = 5'd0; DbgReg = 5'd0;
        step();
        RegWrite = 1'b0;
        expect_val(P_RD1, 32'h0); expect_val(P_DBG, 32'h0); expect_val(P_CNT, 32'd1);
        step();

        // Same-cycle read/write of x7.
        do_write(5'd7, 32'h00000011);
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h00000022; ReadReg1 = 5'd7; ReadReg2 = 5'd7;
        expect_val(P_RD2, 32'h11); expect_val(P_RD1, 32'h11); expect_val(P_CNT, 32'd2);
        step();
        RegWrite = 1'b0;
        expect_val(P_RD2, 32'h22); expect_val(P_RD1, 32'h22); expect_val(P_CNT, 32'd3);
        step();

        // Mid-cycle async reset after prior writes; a write during reset is ignored.
        rst_n = 1'b0; RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h99999999;
        ReadReg1 = 5'd5; ReadReg2 = 5'd7; DbgReg = 5'd5;
        expect_val(P_RD1, 32'h0); expect_val(P_RD2, 32'h0); expect_val(P_DBG, 32'h0); expect_val(P_CNT, 32'h0);
        step();
        rst_n = 1'b1; RegWrite = 1'b0; DbgReg = 5'd9;
        model_clear();
        expect_val(P_DBG, 32'h0); expect_val(P_CNT, 32'h0);
        step();

        // Fill x1..x31 with i*0x01010101 and sweep the debug port.
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
        expect_val(P_CNT, 32'd31);
        for (int i = 0; i < 32; i++) begin
            DbgReg = 5'(i);
            expect_val(P_DBG, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
            step();
        end

        // Wrap the write counter: 65535 writes from reset, then one more.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_clear();
        for (int k = 1; k <= 65535; k++) do_write(5'(((k - 1) % 31) + 1), 32'(k));
        expect_val(P_CNT, 32'h0000FFFF);
        step();
        do_write(5'd2, 32'hCAFEF00D);
        expect_val(P_CNT, 32'h0);
        DbgReg = 5'd1;
        expect_val(P_DBG, 32'd65535);
        step();
        for (int i = 0; i < 32; i++) begin
            DbgReg = 5'(i);
            expect_val(P_DBG, model[i]);
            step();
        end

        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            step();
            budget++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d checks still queued, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
